regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised register file: NUM_REGS x WIDTH storage, one write port and two combinational read ports.
- Adds a per-register pending-write scoreboard (busy bits plus a busy counter), so issue logic can reserve a destination and stall readers until the write-back lands.
- Sits in the decode/write-back stage of the processor datapath.
- Register 0 optionally hardwired to zero.

Parameters:
- WIDTH, 32, data bits per register
- NUM_REGS, 32, number of registers (>=2)
- ADDR_W, $clog2(NUM_REGS), address width (derived)
- ZERO_REG, 1, when 1: register 0 reads 0, is never written and never becomes busy
- CNT_W, $clog2(NUM_REGS+1), busy counter width (derived)

Ports:
- clk  in  1  clock, all state updates on rising edge
- clr  in  1  synchronous active-low reset
- wr_en  in  1  write-back strobe
- wr_addr  in  ADDR_W  write-back destination
- wr_data  in  WIDTH  write-back data
- rd_addr_a  in  ADDR_W  read port A address
- rd_data_a  out  WIDTH  read port A data (combinational)
- rd_busy_a  out  1  register A has a pending write
- rd_addr_b  in  ADDR_W  read port B address
- rd_data_b  out  WIDTH  read port B data (combinational)
- rd_busy_b  out  1  register B has a pending write
- rsv_en  in  1  reserve-destination request
- rsv_addr  in  ADDR_W  register to reserve
- rsv_ok  out  1  reservation accepted this cycle (combinational)
- busy_vec  out  NUM_REGS  registered busy bit per register
- busy_cnt  out  CNT_W  registered count of busy registers

Behaviour:
- Reset (clr=0 at posedge): all registers 0, busy_vec 0, busy_cnt 0. Reset overrides wr_en and rsv_en in the same cycle.
- Write: at posedge, if wr_en=1 and the address is writable (not 0 when ZERO_REG=1), reg[wr_addr] <= wr_data and busy[wr_addr] <= 0. A write to a non-busy register is legal; its busy bit stays 0.
- Reserve acceptance: rsv_ok = rsv_en & (rsv_addr writable) & (~busy[rsv_addr] | (wr_en & wr_addr==rsv_addr)).
  - The last term is same-cycle release-and-re-reserve. The net result is busy=1 and the data written.
  - Rejected reserve: no state change. The requester holds rsv_en (stall).
- rsv_en to register 0 with ZERO_REG=1: rsv_ok=1, no state change (nothing to wait for).
- busy_cnt update: +1 on an accepted reserve of a non-busy register; -1 on a write that clears a busy register not being re-reserved; otherwise unchanged. Never wraps: max NUM_REGS, min 0.
- Reads: rd_data_x = reg[rd_addr_x], 0 for address 0 when ZERO_REG=1. rd_busy_x = busy[rd_addr_x]. Out-of-range addresses (NUM_REGS not a power of 2) read 0, not busy; writes and reserves to them are ignored, rsv_ok=0.
- Latency: a write is visible on read ports the cycle after the write strobe, unless bypass is compiled in.
- Invariant: busy_cnt == popcount(busy_vec) every cycle. Checked by assertion.

Optional Feature:
- Macro REGFILE_WR_BYPASS_EN.
- Defined: if wr_en and rd_addr_x==wr_addr and the address is writable, then rd_data_x = wr_data and rd_busy_x = 0 in the same cycle.
  - Exception: if a same-address reserve is accepted that cycle, rd_busy_x = 1 and rd_data_x is still forwarded.
- Undefined: reads return the pre-write register value and the registered busy bit. Zero-cycle forwarding is absent.

Decomposition:
- Shared package regfile_pkg: default WIDTH/NUM_REGS constants, an addr_is_writable function (ZERO_REG and range check), and the CNT_W derivation.
- One natural sub-module: regfile_read_port (address decode, zero/range masking, optional bypass mux), instantiated twice.
- Storage and scoreboard stay in the top module.

Test Plan:
- Reset: clr=0 for 2 cycles after random writes -> all reads 0, busy_vec=0, busy_cnt=0; wr_en held high during reset has no effect.
- Write/read: write 0xDEADBEEF to r5, then read A=r5, B=r0 next cycle -> rd_data_a=0xDEADBEEF, rd_data_b=0; write 0x1234 to r0 -> r0 still reads 0.
- Scoreboard: reserve r7 -> rsv_ok=1, next cycle busy_vec[7]=1, busy_cnt=1, rd_busy_a=1. Re-reserve r7 -> rsv_ok=0, count stays 1. Write r7=0x55 -> busy_cnt=0, rd_busy_a=0.
- Simultaneous: r9 busy, same cycle wr r9=0xA and reserve r9 -> rsv_ok=1, next cycle busy[9]=1, reg=0xA, busy_cnt unchanged.
- Count saturation: reserve r1..r31 on consecutive cycles -> busy_cnt=31, then reserve r3 rejected; write all -> busy_cnt returns to 0, no underflow on an extra write to a non-busy register.
- Bypass: with REGFILE_WR_BYPASS_EN, wr r4=0x77 and read A=r4 same cycle -> rd_data_a=0x77, rd_busy_a=0; without the macro -> old value of r4.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file with pending-write scoreboard.
package regfile_pkg;

  localparam int DEFAULT_WIDTH    = 32;
  localparam int DEFAULT_NUM_REGS = 32;

  function automatic int cnt_width(input int num_regs);
    return $clog2(num_regs + 1);
  endfunction

  // An address is writable when it is in range and not the hardwired zero register.
  function automatic logic addr_is_writable(input int addr, input int num_regs, input int zero_reg);
    return (addr < num_regs) && !((zero_reg != 0) && (addr == 0));
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Write-back, read and reserve signals of the register file; master drives requests.
interface regfile_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int NUM_REGS = DEFAULT_NUM_REGS
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int CNT_W  = cnt_width(NUM_REGS);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [WIDTH-1:0]  rd_data_a;
  logic              rd_busy_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [WIDTH-1:0]  rd_data_b;
  logic              rd_busy_b;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              rsv_ok;
  logic [NUM_REGS-1:0] busy_vec;
  logic [CNT_W-1:0]  busy_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, rsv_en, rsv_addr,
    input  rd_data_a, rd_busy_a, rd_data_b, rd_busy_b, rsv_ok, busy_vec, busy_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, rsv_en, rsv_addr,
    output rd_data_a, rd_busy_a, rd_data_b, rd_busy_b, rsv_ok, busy_vec, busy_cnt
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: zero/range masking and optional write-back forwarding.
// Forwarding is compiled in with REGFILE_WR_BYPASS_EN.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ZERO_REG = 1,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0][WIDTH-1:0] regs,
  input  logic [NUM_REGS-1:0]            busy,
  input  logic [ADDR_W-1:0]              rd_addr,
  input  logic                           wr_ok,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           rsv_take,
  input  logic [ADDR_W-1:0]              rsv_addr,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           rd_busy
);

  logic readable;

  always_comb begin
    readable = addr_is_writable(int'(rd_addr), NUM_REGS, ZERO_REG);
    rd_data  = readable ? regs[rd_addr] : '0;
    rd_busy  = readable ? busy[rd_addr] : 1'b0;
`ifdef REGFILE_WR_BYPASS_EN
    // wr_ok already excludes register 0 and out-of-range targets.
    if (wr_ok && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
      rd_busy = rsv_take && (rsv_addr == rd_addr);
    end
`endif
  end

`ifndef REGFILE_WR_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{wr_ok, wr_addr, wr_data, rsv_take, rsv_addr};
`endif

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy bits and busy counter for issue/write-back tracking.
// Optional same-cycle write forwarding: define REGFILE_WR_BYPASS_EN.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ZERO_REG = 1
) (
  input logic                 clk,
  input logic                 clr,
  regfile_scoreboard_if.slave bus
);

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int CNT_W  = cnt_width(NUM_REGS);

  logic [NUM_REGS-1:0][WIDTH-1:0] regs_reg;
  logic [NUM_REGS-1:0]            busy_reg, busy_next;
  logic [CNT_W-1:0]               cnt_reg, cnt_next;
  logic wr_ok, rsv_writable, rsv_zero, rsv_was_busy, wr_was_busy;
  logic rsv_take, rsv_ok, cnt_inc, cnt_dec;

  always_comb begin
    wr_ok        = bus.wr_en && addr_is_writable(int'(bus.wr_addr), NUM_REGS, ZERO_REG);
    rsv_writable = addr_is_writable(int'(bus.rsv_addr), NUM_REGS, ZERO_REG);
    rsv_zero     = (ZERO_REG != 0) && (bus.rsv_addr == '0);
    rsv_was_busy = rsv_writable ? busy_reg[bus.rsv_addr] : 1'b0;
    wr_was_busy  = wr_ok ? busy_reg[bus.wr_addr] : 1'b0;
    // A busy destination may be re-reserved in the cycle its write-back lands.
    rsv_take = bus.rsv_en && rsv_writable &&
               (!rsv_was_busy || (wr_ok && (bus.wr_addr == bus.rsv_addr)));
    rsv_ok   = rsv_take || (bus.rsv_en && rsv_zero);

    busy_next = busy_reg;
    if (wr_ok)    busy_next[bus.wr_addr]  = 1'b0;
    if (rsv_take) busy_next[bus.rsv_addr] = 1'b1;

    cnt_inc  = rsv_take && !rsv_was_busy;
    cnt_dec  = wr_was_busy && !(rsv_take && (bus.rsv_addr == bus.wr_addr));
    cnt_next = cnt_reg;
    if (cnt_inc && !cnt_dec && (cnt_reg != CNT_W'(NUM_REGS))) cnt_next = cnt_reg + 1'b1;
    if (cnt_dec && !cnt_inc && (cnt_reg != '0))               cnt_next = cnt_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      busy_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      busy_reg <= busy_next;
      cnt_reg  <= cnt_next;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
    always_ff @(posedge clk) begin
      if (!clr)
        regs_reg[gi] <= '0;
      else if (wr_ok && (bus.wr_addr == ADDR_W'(gi)))
        regs_reg[gi] <= bus.wr_data;
    end
  end

  regfile_read_port #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .ZERO_REG(ZERO_REG), .ADDR_W(ADDR_W)) u_port_a (
    .regs(regs_reg), .busy(busy_reg), .rd_addr(bus.rd_addr_a),
    .wr_ok(wr_ok), .wr_addr(bus.wr_addr), .wr_data(bus.wr_data),
    .rsv_take(rsv_take), .rsv_addr(bus.rsv_addr),
    .rd_data(bus.rd_data_a), .rd_busy(bus.rd_busy_a)
  );

  regfile_read_port #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .ZERO_REG(ZERO_REG), .ADDR_W(ADDR_W)) u_port_b (
    .regs(regs_reg), .busy(busy_reg), .rd_addr(bus.rd_addr_b),
    .wr_ok(wr_ok), .wr_addr(bus.wr_addr), .wr_data(bus.wr_data),
    .rsv_take(rsv_take), .rsv_addr(bus.rsv_addr),
    .rd_data(bus.rd_data_b), .rd_busy(bus.rd_busy_b)
  );

  assign bus.rsv_ok   = rsv_ok;
  assign bus.busy_vec = busy_reg;
  assign bus.busy_cnt = cnt_reg;

  cnt_matches_popcount: assert property (@(posedge clk) disable iff (!clr)
    cnt_reg == CNT_W'($countones(busy_reg)));

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard; expected values queued at stimulus, popped at observation.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  localparam int WIDTH    = 32;
  localparam int NUM_REGS = 32;

  logic        clk;
  logic        clr;
  logic [31:0] exp_q[$];
  logic [31:0] exp;
  int          n_checks = 0;
  int          n_fail   = 0;

  regfile_scoreboard_if #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) bus ();

  regfile_scoreboard #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .ZERO_REG(1)) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en  = 1'b0;
    bus.rsv_en = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    $display("[%0t] write r%0d = %h", $time, a, d);
  endtask

  task automatic test_reset();
    clr = 1'b0;
    idle();
    bus.wr_addr = '0; bus.wr_data = '0; bus.rsv_addr = '0;
    bus.rd_addr_a = '0; bus.rd_addr_b = '0;
    tick(); tick();
    clr = 1'b1;
    for (int i = 1; i <= 4; i++) do_write(5'(i), $urandom);
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd10;
    tick();
    // reset with write and reserve requests held active
    clr = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 32'hFFFF_FFFF;
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd11;
    tick(); tick();
    clr = 1'b1;
    idle();
    $display("[%0t] reset released", $time);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (bus.busy_vec !== exp) begin n_fail++; $display("FAIL reset_busy_vec: got %h expected %h", bus.busy_vec, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (32'(bus.busy_cnt) !== exp) begin n_fail++; $display("FAIL reset_busy_cnt: got %0d expected %0d", bus.busy_cnt, exp); end
    for (int i = 0; i < NUM_REGS; i++) begin
      bus.rd_addr_a = 5'(i);
      bus.rd_addr_b = 5'(NUM_REGS - 1 - i);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      #1;
      exp = exp_q.pop_front(); n_checks++;
      if (bus.rd_data_a !== exp) begin n_fail++; $display("FAIL reset_rd_a r%0d: got %h expected %h", i, bus.rd_data_a, exp); end
      exp = exp_q.pop_front(); n_checks++;
      if (bus.rd_data_b !== exp) begin n_fail++; $display("FAIL reset_rd_b r%0d: got %h expected %h", NUM_REGS - 1 - i, bus.rd_data_b, exp); end
      exp = exp_q.pop_front(); n_checks++;
      if (32'(bus.rd_busy_a) !== exp) begin n_fail++; $display("FAIL reset_busy_a r%0d: got %b expected %0d", i, bus.rd_busy_a, exp); end
    end
  endtask

  task automatic test_write_read();
    do_write(5'd5, 32'hDEAD_BEEF);
    bus.rd_addr_a = 5'd5; bus.rd_addr_b = 5'd0;
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (bus.rd_data_a !== exp) begin n_fail++; $display("FAIL wr_rd_r5: got %h expected %h", bus.rd_data_a, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (bus.rd_data_b !== exp) begin n_fail++; $display("FAIL wr_rd_r0: got %h expected %h", bus.rd_data_b, exp); end
    do_write(5'd0, 32'h0000_1234);
    bus.rd_addr_a = 5'd0;
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (bus.rd_data_a !== exp) begin n_fail++; $display("FAIL wr_r0_ignored: got %h expected %h", bus.rd_data_a, exp); end
  endtask

  task automatic test_scoreboard();
    bus.rd_addr_a = 5'd7;
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd7;
    exp_q.push_back(32'h1);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (32'(bus.rsv_ok) !== exp) begin n_fail++; $display("FAIL rsv_r7_ok: got %b expected %0d", bus.rsv_ok, exp); end
    tick();
    idle();
    $display("[%0t] reserve r7", $time);
    exp_q.push_back(32'h1); exp_q.push_back(32'h1); exp_q.push_back(32'h1);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (32'(bus.busy_vec[7]) !== exp) begin n_fail++; $display("FAIL rsv_r7_busy_vec: got %b expected %0d", bus.busy_vec[7], exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (32'(bus.busy_cnt) !== exp) begin n_fail++; $display("FAIL rsv_r7_cnt: got %0d expected %0d", bus.busy_cnt, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (32'(bus.rd_busy_a) !== exp) begin n_fail++; $display("FAIL rsv_r7_rd_busy: got %b expected %0d", bus.rd_busy_a, exp); end
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd7;
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (32'(bus.rsv_ok) !== exp) begin n_fail++; $display("FAIL rersv_r7_rejected: got %b expected %0d", bus.rsv_ok, exp); end
    tick();
    idle();
    exp_q.push_back(32'h1);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (32'(bus.busy_cnt) !== exp) begin n_fail++; $display("FAIL rersv_r7_cnt: got %0d expected %0d", bus.busy_cnt, exp); end
    do_write(5'd7, 32'h55);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h55);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (32'(bus.busy_cnt) !== exp) begin n_fail++; $display("FAIL wb_r7_cnt: got %0d expected %0d", bus.busy_cnt, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (32'(bus.rd_busy_a) !== exp) begin n_fail++; $display("FAIL wb_r7_rd_busy: got %b expected %0d", bus.rd_busy_a, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (bus.rd_data_a !== exp) begin n_fail++; $display("FAIL wb_r7_data: got %h expected %h", bus.rd_data_a, exp); end
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0;
    exp_q.push_back(32'h1);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (32'(bus.rsv_ok) !== exp) begin n_fail++; $display("FAIL rsv_r0_ok: got %b expected %0d", bus.rsv_ok, exp); end
    tick();
    idle();
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (bus.busy_vec !== exp) begin n_fail++; $display("FAIL rsv_r0_busy_vec: got %h expected %h", bus.busy_vec, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (32'(bus.busy_cnt) !== exp) begin n_fail++; $display("FAIL rsv_r0_cnt: got %0d expected %0d", bus.busy_cnt, exp); end
  endtask

  task automatic test_simultaneous();
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9;
    tick();
    idle();
    $display("[%0t] reserve r9", $time);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'hA;
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9;
    exp_q.push_back(32'h1);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (32'(bus.rsv_ok) !== exp) begin n_fail++; $display("FAIL sim_rsv_ok: got %b expected %0d", bus.rsv_ok, exp); end
    tick();
    idle();
    $display("[%0t] write r9 = a with re-reserve", $time);
    bus.rd_addr_a = 5'd9;
    exp_q.push_back(32'h1); exp_q.push_back(32'hA); exp_q.push_back(32'h1);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (32'(bus.busy_vec[9]) !== exp) begin n_fail++; $display("FAIL sim_busy_r9: got %b expected %0d", bus.busy_vec[9], exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (bus.rd_data_a !== exp) begin n_fail++; $display("FAIL sim_data_r9: got %h expected %h", bus.rd_data_a, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (32'(bus.busy_cnt) !== exp) begin n_fail++; $display("FAIL sim_cnt: got %0d expected %0d", bus.busy_cnt, exp); end
    do_write(5'd9, 32'hB);
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (32'(bus.busy_cnt) !== exp) begin n_fail++; $display("FAIL sim_release_cnt: got %0d expected %0d", bus.busy_cnt, exp); end
  endtask

  task automatic test_count_saturation();
    for (int i = 1; i < NUM_REGS; i++) begin
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'(i);
      exp_q.push_back(32'h1);
      #1;
      exp = exp_q.pop_front(); n_checks++;
      if (32'(bus.rsv_ok) !== exp) begin n_fail++; $display("FAIL sat_rsv_ok r%0d: got %b expected %0d", i, bus.rsv_ok, exp); end
      tick();
    end
    idle();
    $display("[%0t] reserved r1..r31", $time);
    exp_q.push_back(32'd31); exp_q.push_back(32'hFFFF_FFFE);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (32'(bus.busy_cnt) !== exp) begin n_fail++; $display("FAIL sat_cnt_full: got %0d expected %0d", bus.busy_cnt, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (bus.busy_vec !== exp) begin n_fail++; $display("FAIL sat_busy_vec: got %h expected %h", bus.busy_vec, exp); end
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (32'(bus.rsv_ok) !== exp) begin n_fail++; $display("FAIL sat_rsv_r3_rejected: got %b expected %0d", bus.rsv_ok, exp); end
    tick();
    idle();
    exp_q.push_back(32'd31);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (32'(bus.busy_cnt) !== exp) begin n_fail++; $display("FAIL sat_cnt_hold: got %0d expected %0d", bus.busy_cnt, exp); end
    for (int i = 1; i < NUM_REGS; i++) do_write(5'(i), 32'(i * 3));
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (32'(bus.busy_cnt) !== exp) begin n_fail++; $display("FAIL sat_cnt_drained: got %0d expected %0d", bus.busy_cnt, exp); end
    do_write(5'd2, 32'd99);
    bus.rd_addr_b = 5'd20;
    exp_q.push_back(32'h0); exp_q.push_back(32'd60);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (32'(bus.busy_cnt) !== exp) begin n_fail++; $display("FAIL sat_no_underflow: got %0d expected %0d", bus.busy_cnt, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (bus.rd_data_b !== exp) begin n_fail++; $display("FAIL sat_rd_r20: got %h expected %h", bus.rd_data_b, exp); end
  endtask

  task automatic test_bypass();
    // r4 holds 12 from the drain writes
    bus.wr_en = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 32'h77;
    bus.rd_addr_a = 5'd4;
`ifdef REGFILE_WR_BYPASS_EN
    exp_q.push_back(32'h77);
`else
    exp_q.push_back(32'd12);
`endif
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (bus.rd_data_a !== exp) begin n_fail++; $display("FAIL byp_data_same_cycle: got %h expected %h", bus.rd_data_a, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (32'(bus.rd_busy_a) !== exp) begin n_fail++; $display("FAIL byp_busy_same_cycle: got %b expected %0d", bus.rd_busy_a, exp); end
    tick();
    idle();
    $display("[%0t] write r4 = 00000077", $time);
    exp_q.push_back(32'h77);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (bus.rd_data_a !== exp) begin n_fail++; $display("FAIL byp_data_next_cycle: got %h expected %h", bus.rd_data_a, exp); end
`ifdef REGFILE_WR_BYPASS_EN
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd4;
    tick();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 32'h88;
    exp_q.push_back(32'h88); exp_q.push_back(32'h1);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (bus.rd_data_a !== exp) begin n_fail++; $display("FAIL byp_rersv_data: got %h expected %h", bus.rd_data_a, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (32'(bus.rd_busy_a) !== exp) begin n_fail++; $display("FAIL byp_rersv_busy: got %b expected %0d", bus.rd_busy_a, exp); end
    tick();
    idle();
    do_write(5'd4, 32'h0);
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_simultaneous();
    test_count_saturation();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
